uart_rxtx: RTL and testbench

Full-duplex 8-bit UART with a runtime-programmable fractional baud generator, optional even/odd parity and 1–3 stop bits. Sits between a byte-stream client (valid/ready on TX, valid pulse on RX) and the physical serial pins. Both directions share one 16×-oversampling tick. All configuration comes from control-register inputs.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_rxtx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_rxtx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rxtx UART.
//   - TX/RX FSM state enums
//   - stop-bit field encodings and helpers
//   - oversampling rate and mid-bit sample point
package uart_pkg;

  // Ticks per serial bit and the tick (1-based) at which a bit is sampled.
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_POINT = 8;

  // cr_sbit encodings; any other value selects three stop bits.
  localparam logic [1:0] SBIT_ONE   = 2'b00;
  localparam logic [1:0] SBIT_TWO   = 2'b01;
  localparam logic [1:0] SBIT_THREE = 2'b10;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  // Index of the final stop bit (0-based) for a cr_sbit setting.
  function automatic logic [1:0] last_stop_idx(input logic [1:0] sbit);
    logic [1:0] idx;
    case (sbit)
      SBIT_ONE: idx = 2'd0;
      SBIT_TWO: idx = 2'd1;
      default:  idx = 2'd2;
    endcase
    return idx;
  endfunction

  // Parity bit value for a byte: even -> XOR of data, odd -> XNOR of data.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate tick generator shared by both UART directions.
// Produces a one-cycle tick at an average rate of
// f_clk * baud_freq_i / (baud_freq_i + baud_limit_i), i.e. 16x the baud rate.
// Ports:
//   clk          system clock
//   reset_n      synchronous reset, active HIGH despite the name
//   baud_freq_i  accumulator increment
//   baud_limit_i accumulator wrap threshold
//   tick_o       registered one-cycle oversampling tick
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] baud_freq_i,
  input  logic [15:0] baud_limit_i,
  output logic        tick_o
);

  logic [15:0] acc;

  // acc never exceeds limit + freq, which fits in 16 bits for any valid setting.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      acc    <= '0;
      tick_o <= 1'b0;
    end else if (acc >= baud_limit_i) begin
      acc    <= acc - baud_limit_i;
      tick_o <= 1'b1;
    end else begin
      acc    <= acc + baud_freq_i;
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rxtx.sv
// Full-duplex 8-bit UART with runtime-programmable fractional baud rate,
// optional even/odd parity and 1-3 stop bits. Both directions share one
// 16x oversampling tick.
// Ports:
//   clk            system clock
//   reset_n        synchronous reset, active HIGH despite the name
//   tx_data_i      byte to transmit
//   tx_valid_i     transmit request; accepted when tx_ready_o is high
//   tx_ready_o     transmitter idle
//   rx_data_o      last good received byte, held until the next good frame
//   rx_pbit_error  parity mismatch on the last good frame, held like rx_data_o
//   rx_valid_o     one-cycle pulse when a frame completes with a valid stop bit
//   uart_rx        asynchronous serial input, idle high
//   uart_tx        serial output, idle high
//   cr_pbit        1 = parity bit present
//   cr_sbit        stop bits: 00 = 1, 01 = 2, 1x = 3
//   cr_ptype       0 = even parity, 1 = odd parity
//   cr_baud_freq   baud accumulator increment
//   cr_baud_limit  baud accumulator threshold
module uart_rxtx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_pbit_error,
  output logic        rx_valid_o,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        cr_pbit,
  input  logic [1:0]  cr_sbit,
  input  logic        cr_ptype,
  input  logic [15:0] cr_baud_freq,
  input  logic [15:0] cr_baud_limit
);

  localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MidTick  = 4'(SAMPLE_POINT - 1);

  logic tick;

  uart_baud_gen u_baud_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_freq_i  (cr_baud_freq),
    .baud_limit_i (cr_baud_limit),
    .tick_o       (tick)
  );

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e  tx_state;
  logic [7:0] tx_shift;
  logic       tx_par;
  logic       tx_pbit;
  logic [1:0] tx_last_stop;
  logic [1:0] tx_stop_idx;
  logic [2:0] tx_bit_idx;
  logic [3:0] tx_cnt;
  logic       tx_bit_done;

  assign tx_bit_done = tick && (tx_cnt == LastTick);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      tx_state     <= TxIdle;
      uart_tx      <= 1'b1;
      tx_ready_o   <= 1'b1;
      tx_shift     <= '0;
      tx_par       <= 1'b0;
      tx_pbit      <= 1'b0;
      tx_last_stop <= '0;
      tx_stop_idx  <= '0;
      tx_bit_idx   <= '0;
      tx_cnt       <= '0;
    end else begin
      // Bit timer free-runs modulo 16 ticks whenever a frame is in flight.
      if (tx_state != TxIdle && tick) begin
        tx_cnt <= (tx_cnt == LastTick) ? '0 : tx_cnt + 4'd1;
      end

      unique case (tx_state)
        TxIdle: begin
          if (tx_valid_i && tx_ready_o) begin
            // Snapshot data and framing so config writes cannot disturb this frame.
            tx_shift     <= tx_data_i;
            tx_par       <= parity_bit(tx_data_i, cr_ptype);
            tx_pbit      <= cr_pbit;
            tx_last_stop <= last_stop_idx(cr_sbit);
            tx_ready_o   <= 1'b0;
            tx_state     <= TxStart;
          end
        end

        TxStart: begin
          if (tick) begin
            if (uart_tx) begin
              // First tick after acceptance opens the start bit and aligns the timer.
              uart_tx <= 1'b0;
              tx_cnt  <= '0;
            end else if (tx_cnt == LastTick) begin
              uart_tx    <= tx_shift[0];
              tx_bit_idx <= '0;
              tx_state   <= TxData;
            end
          end
        end

        TxData: begin
          if (tx_bit_done) begin
            if (tx_bit_idx == 3'd7) begin
              if (tx_pbit) begin
                uart_tx  <= tx_par;
                tx_state <= TxParity;
              end else begin
                uart_tx     <= 1'b1;
                tx_stop_idx <= '0;
                tx_state    <= TxStop;
              end
            end else begin
              tx_shift   <= {1'b0, tx_shift[7:1]};
              uart_tx    <= tx_shift[1];
              tx_bit_idx <= tx_bit_idx + 3'd1;
            end
          end
        end

        TxParity: begin
          if (tx_bit_done) begin
            uart_tx     <= 1'b1;
            tx_stop_idx <= '0;
            tx_state    <= TxStop;
          end
        end

        TxStop: begin
          if (tx_bit_done) begin
            if (tx_stop_idx == tx_last_stop) begin
              tx_ready_o <= 1'b1;
              tx_state   <= TxIdle;
            end else begin
              tx_stop_idx <= tx_stop_idx + 2'd1;
            end
          end
        end

        default: begin
          uart_tx    <= 1'b1;
          tx_ready_o <= 1'b1;
          tx_state   <= TxIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_e  rx_state;
  logic [7:0] rx_shift;
  logic [2:0] rx_bit_idx;
  logic [3:0] rx_cnt;
  logic       rx_pbit;
  logic       rx_ptype;
  logic       rx_par;
  logic       rx_bit_done;

  // After the start-bit check the timer is re-zeroed, so every later wrap
  // lands on the middle (8th tick) of the next bit.
  assign rx_bit_done = tick && (rx_cnt == LastTick);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_state      <= RxIdle;
      rx_shift      <= '0;
      rx_bit_idx    <= '0;
      rx_cnt        <= '0;
      rx_pbit       <= 1'b0;
      rx_ptype      <= 1'b0;
      rx_par        <= 1'b0;
      rx_data_o     <= '0;
      rx_pbit_error <= 1'b0;
      rx_valid_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;

      if (rx_state != RxIdle && tick) begin
        rx_cnt <= (rx_cnt == LastTick) ? '0 : rx_cnt + 4'd1;
      end

      unique case (rx_state)
        RxIdle: begin
          if (rx_prev && !rx_sync) begin
            rx_pbit  <= cr_pbit;
            rx_ptype <= cr_ptype;
            rx_cnt   <= '0;
            rx_state <= RxStart;
          end
        end

        RxStart: begin
          if (tick && rx_cnt == MidTick) begin
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            // Line back high at mid start bit: treat as a glitch.
            rx_state   <= rx_sync ? RxIdle : RxData;
          end
        end

        RxData: begin
          if (rx_bit_done) begin
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            rx_bit_idx <= rx_bit_idx + 3'd1;
            if (rx_bit_idx == 3'd7) begin
              rx_state <= rx_pbit ? RxParity : RxStop;
            end
          end
        end

        RxParity: begin
          if (rx_bit_done) begin
            rx_par   <= rx_sync;
            rx_state <= RxStop;
          end
        end

        RxStop: begin
          // Only the first stop bit is checked; later stop bits overlap idle.
          if (rx_bit_done) begin
            rx_state <= RxIdle;
            if (rx_sync) begin
              rx_data_o     <= rx_shift;
              rx_pbit_error <= rx_pbit && (rx_par != parity_bit(rx_shift, rx_ptype));
              rx_valid_o    <= 1'b1;
            end
          end
        end

        default: rx_state <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rxtx.sv
module tb_uart_rxtx;

  localparam int F921   = 4608;
  localparam int L921   = 11017;
  localparam int F115   = 576;
  localparam int L115   = 15049;
  localparam int BitCyc = 54;   // cycles per bit at 921600 baud, 50 MHz
  localparam int Bit115 = 434;  // cycles per bit at 115200 baud, 50 MHz

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_pbit_error;
  logic        rx_valid_o;
  logic        uart_rx;
  logic        uart_tx;
  logic        cr_pbit = 1'b0;
  logic [1:0]  cr_sbit = 2'b00;
  logic        cr_ptype = 1'b0;
  logic [15:0] cr_baud_freq = 16'(F921);
  logic [15:0] cr_baud_limit = 16'(L921);

  logic loop_en = 1'b0;
  logic rx_drive = 1'b1;
  assign uart_rx = loop_en ? uart_tx : rx_drive;

  always #10 clk = ~clk;

  uart_rxtx dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .rx_data_o     (rx_data_o),
    .rx_pbit_error (rx_pbit_error),
    .rx_valid_o    (rx_valid_o),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .cr_pbit       (cr_pbit),
    .cr_sbit       (cr_sbit),
    .cr_ptype      (cr_ptype),
    .cr_baud_freq  (cr_baud_freq),
    .cr_baud_limit (cr_baud_limit)
  );

  int checks = 0;
  int errors = 0;

  // Passive receive monitor: counts pulses and captures the byte delivered with each.
  int         rx_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  always @(negedge clk) begin
    if (rx_valid_o) begin
      rx_cnt    = rx_cnt + 1;
      last_data = rx_data_o;
      last_perr = rx_pbit_error;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: frame length in bits and value of serial bit k of a frame.
  function automatic int frame_bits(input logic pbit, input logic [1:0] sbit);
    int nstop;
    nstop = (sbit == 2'b00) ? 1 : (sbit == 2'b01) ? 2 : 3;
    return 9 + (pbit ? 1 : 0) + nstop;
  endfunction

  function automatic logic model_bit(input logic [7:0] b, input logic pbit, input logic ptype,
                                     input int k);
    int ones;
    ones = $countones(b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    // Even: total ones (data + parity) even; odd: total ones odd.
    if (pbit && k == 9) return ptype ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  // Send one byte through the transmitter; returns cycles tx_ready_o stayed low.
  // With disturb set, config and a second request are thrown at the busy UART.
  task automatic tx_frame(input logic [7:0] b, input logic disturb, output int low);
    int guard;
    guard = 0;
    while (!tx_ready_o && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    low = 0;
    while (!tx_ready_o && low < 5000) begin
      @(negedge clk);
      low++;
      if (disturb && low == 30) begin
        cr_pbit  = 1'($urandom);
        cr_ptype = 1'($urandom);
        cr_sbit  = 2'($urandom);
      end
      if (disturb && low == 40) begin
        tx_data_i  = ~b;
        tx_valid_i = 1'b1;
      end
      if (disturb && low == 45) tx_valid_i = 1'b0;
    end
    tx_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       has_par;
    logic       par;
    logic       stop;
    logic       pbit;
    logic       ptype;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  task automatic drive_bit(input logic v);
    rx_drive = v;
    repeat (BitCyc) @(negedge clk);
  endtask

  task automatic drive_frame(input vec_t v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v.data[i]);
    if (v.has_par) drive_bit(v.par);
    drive_bit(v.stop);
    rx_drive = 1'b1;
    repeat (3 * BitCyc) @(negedge clk);
  endtask

  vec_t vecs[8];
  logic wave [0:5399];

  initial begin
    int         low, n0, exp_cyc, start, rise, t, nb;
    logic [7:0] b;
    logic [3:0] cfg;
    vec_t       v;

    // Injected frames: {data, has_par, par, stop, rx pbit, rx ptype, exp valid, data, perr}
    vecs[0] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1};  // odd frame, even rx
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1};  // bad stop: held
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};  // bad stop: held
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset uart_tx", 32'(uart_tx), 1);
    check("reset tx_ready", 32'(tx_ready_o), 1);
    check("reset rx_valid", 32'(rx_valid_o), 0);
    check("reset rx_data", 32'(rx_data_o), 0);
    check("reset rx_perr", 32'(rx_pbit_error), 0);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);

    // Randomized loopback over every framing configuration at 921600 baud
    loop_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int j = 0; j < 4; j++) begin
        cfg = 4'(c);
        b = (j == 0) ? 8'h00 : (j == 1) ? 8'hFF : 8'($urandom);
        cr_ptype = cfg[3];
        cr_pbit  = cfg[2];
        cr_sbit  = cfg[1:0];
        nb = frame_bits(cfg[2], cfg[1:0]);
        n0 = rx_cnt;
        tx_frame(b, 1'b1, low);
        exp_cyc = nb * 16 * (F921 + L921) / F921;
        repeat (2) @(negedge clk);
        check("loop rx pulses", rx_cnt, n0 + 1);
        check("loop rx data", 32'(last_data), 32'(b));
        check("loop rx perr", 32'(last_perr), 0);
        check_range("loop ready low", low, exp_cyc - 3, exp_cyc + 7);
      end
    end

    // Bit timing at 115200 baud, even parity, two stop bits, byte 0xA5
    cr_baud_freq  = 16'(F115);
    cr_baud_limit = 16'(L115);
    cr_pbit  = 1'b1;
    cr_ptype = 1'b0;
    cr_sbit  = 2'b01;
    repeat (40) @(negedge clk);
    n0 = rx_cnt;
    tx_data_i  = 8'hA5;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    start = -1;
    rise  = -1;
    for (int n = 0; n < 5400; n++) begin
      wave[n] = uart_tx;
      if (start < 0 && uart_tx == 1'b0) start = n;
      if (rise < 0 && tx_ready_o) rise = n;
      @(negedge clk);
    end
    check_range("start latency", start, 0, 28);
    if (start < 0) start = 0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("tx bit %0d", k), 32'(wave[start + Bit115 * k + Bit115 / 2]),
            32'(model_bit(8'hA5, 1'b1, 1'b0, k)));
    end
    for (int k = 1; k < 12; k++) begin
      if (model_bit(8'hA5, 1'b1, 1'b0, k) != model_bit(8'hA5, 1'b1, 1'b0, k - 1)) begin
        t = -1;
        for (int i = start + Bit115 * k - 8; i <= start + Bit115 * k + 8; i++) begin
          if (t < 0 && wave[i] == model_bit(8'hA5, 1'b1, 1'b0, k)) t = i - start;
        end
        check_range($sformatf("bit edge %0d", k), t, Bit115 * k - 2, Bit115 * k + 2);
      end
    end
    check_range("ready low span", rise - start, 12 * Bit115 - 4, 12 * Bit115 + 4);
    check("timing rx pulses", rx_cnt, n0 + 1);
    check("timing rx data", 32'(last_data), 32'h A5);
    check("timing rx perr", 32'(last_perr), 0);

    // Table-driven injected frames at 921600 baud
    loop_en       = 1'b0;
    rx_drive      = 1'b1;
    cr_baud_freq  = 16'(F921);
    cr_baud_limit = 16'(L921);
    repeat (50) @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      cr_pbit  = vecs[r].pbit;
      cr_ptype = vecs[r].ptype;
      n0 = rx_cnt;
      drive_frame(vecs[r]);
      check($sformatf("vec%0d pulses", r), rx_cnt, n0 + (vecs[r].exp_valid ? 1 : 0));
      check($sformatf("vec%0d rx_data", r), 32'(rx_data_o), 32'(vecs[r].exp_data));
      check($sformatf("vec%0d rx_perr", r), 32'(rx_pbit_error), 32'(vecs[r].exp_perr));
    end

    // Glitch: ~4-tick low pulse must not start a frame
    n0 = rx_cnt;
    rx_drive = 1'b0;
    repeat (14) @(negedge clk);
    rx_drive = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch pulses", rx_cnt, n0);
    check("glitch rx_data held", 32'(rx_data_o), 32'h5A);
    cr_pbit = 1'b0;
    v = '{8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
    n0 = rx_cnt;
    drive_frame(v);
    check("post-glitch pulses", rx_cnt, n0 + 1);
    check("post-glitch rx_data", 32'(rx_data_o), 32'h C3);

    // Reset in the middle of transmitting 0xFF, then a clean 0x3C
    loop_en  = 1'b1;
    cr_pbit  = 1'b0;
    cr_ptype = 1'b0;
    cr_sbit  = 2'b00;
    tx_data_i  = 8'hFF;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    repeat (20) @(negedge clk);
    check("pre-reset start bit", 32'(uart_tx), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid reset uart_tx", 32'(uart_tx), 1);
    check("mid reset tx_ready", 32'(tx_ready_o), 1);
    check("mid reset rx_data", 32'(rx_data_o), 0);
    check("mid reset rx_valid", 32'(rx_valid_o), 0);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    cr_pbit  = 1'b1;
    cr_ptype = 1'b1;
    cr_sbit  = 2'b10;
    n0 = rx_cnt;
    tx_frame(8'h3C, 1'b0, low);
    repeat (2) @(negedge clk);
    exp_cyc = frame_bits(1'b1, 2'b10) * 16 * (F921 + L921) / F921;
    check("after reset pulses", rx_cnt, n0 + 1);
    check("after reset rx_data", 32'(last_data), 32'h3C);
    check("after reset rx_perr", 32'(last_perr), 0);
    check_range("after reset ready low", low, exp_cyc - 3, exp_cyc + 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
